// File: rtl/pe_data_distributor.sv
// pe_data_distributor: scatters a single word stream into per-PE lane registers and presents each frame under valid/ready
//   clk, rst     : clock, synchronous active-high reset
//   in_valid/in_ready/in_last/mode/sel_in/data_in : input word stream (mode 0 addressed, 1 sequential)
//   out_valid/out_ready/data_out/lane_valid        : assembled frame towards the PE array
//   drop         : one-cycle pulse when an accepted word targets a lane >= NUM_PES
module pe_data_distributor #(
    parameter int NUM_PES   = 16,
    parameter int DATA_TYPE = 8,
    parameter int NUM_SEL   = $clog2(NUM_PES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic                           mode,
    input  logic [NUM_SEL-1:0]             sel_in,
    input  logic [DATA_TYPE-1:0]           data_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_PES*DATA_TYPE-1:0]   data_out,
    output logic [NUM_PES-1:0]             lane_valid,
    output logic                           drop
);
    typedef enum logic {FILL, PRESENT} state_t;
    state_t                 r_state, w_state_nx;
    logic [DATA_TYPE-1:0]   r_data [NUM_PES];
    logic [NUM_PES-1:0]     r_lane_valid;
    logic [NUM_SEL-1:0]     r_fill_ptr, w_lane;
    logic                   r_frame_open, r_mode_q, r_drop;
    logic                   w_mode, w_accept, w_in_range, w_done;
    assign in_ready   = (r_state == FILL) && !rst;
    assign out_valid  = r_state == PRESENT;
    assign w_accept   = in_valid && in_ready;
    // the first beat of a frame steers with the live mode; later beats use the latched one
    assign w_mode     = r_frame_open ? r_mode_q : mode;
    assign w_lane     = w_mode ? r_fill_ptr : sel_in;
    assign w_in_range = int'(w_lane) < NUM_PES;
    // writing the last lane in sequential mode closes the frame even without in_last
    assign w_done     = w_accept && (in_last || (w_mode && int'(w_lane) == NUM_PES - 1));
    assign lane_valid = r_lane_valid;
    assign drop       = r_drop;
    for (genvar g = 0; g < NUM_PES; g++) begin : g_lane
        assign data_out[g*DATA_TYPE +: DATA_TYPE] = r_data[g];
    end
    always_comb begin
        w_state_nx = r_state;
        if (r_state == FILL)
            w_state_nx = w_done ? PRESENT : FILL;
        else
            w_state_nx = out_ready ? FILL : PRESENT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FILL;
            r_lane_valid <= '0;
            r_fill_ptr   <= '0;
            r_frame_open <= 1'b0;
            r_mode_q     <= 1'b0;
            r_drop       <= 1'b0;
            for (int i = 0; i < NUM_PES; i++)
                r_data[i] <= '0;
        end else begin
            r_state <= w_state_nx;
            r_drop  <= w_accept && !w_in_range;
            if (w_accept) begin
                if (!r_frame_open) begin
                    r_mode_q     <= mode;
                    r_frame_open <= 1'b1;
                end
                if (w_mode)
                    r_fill_ptr <= r_fill_ptr + NUM_SEL'(1);
                if (w_in_range) begin
                    r_data[w_lane]       <= data_in;
                    r_lane_valid[w_lane] <= 1'b1;
                end
            end
            // data is kept after hand-off; lane_valid masks the stale lanes
            if (out_valid && out_ready) begin
                r_lane_valid <= '0;
                r_fill_ptr   <= '0;
                r_frame_open <= 1'b0;
            end
        end
    end
endmodule
